// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_access_stage_pkg
// Description : Shared definitions for the MEM pipeline stage: datapath
//               width default, memory opcodes, stage state encoding and a
//               helper that classifies memory instructions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int WORD_SIZE_DEF = 16;

    // Opcodes known to this stage; everything else is an ALU pass-through.
    localparam logic [3:0] ADI_OP = 4'd4;
    localparam logic [3:0] ORI_OP = 4'd5;
    localparam logic [3:0] LWD_OP = 4'd7;
    localparam logic [3:0] SWD_OP = 4'd8;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] opcode);
        return (opcode == LWD_OP) || (opcode == SWD_OP);
    endfunction

endpackage : mem_access_stage_pkg
`default_nettype wire

// File: rtl/mem_access_stage_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles spent waiting for a memory acknowledge.
//               expire is asserted combinationally during the MAX_WAIT-th
//               enabled cycle so the owner can act on it at that edge.
// Ports       : clk, reset  - clock / synchronous active-high reset
//               clear       - return count to zero
//               enable      - count this cycle
//               expire      - this enabled cycle is the MAX_WAIT-th one
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of completed wait cycles, so LAST marks the final one.
    assign expire = enable && (count == LAST);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage after the ALU. ALU results retire one
//               cycle after acceptance; LWD/SWD run a req/ack transaction
//               with data memory (address = ALU result) and retire on ack,
//               or on timeout with mem_error. wb_* are registered and hold
//               their last value so forwarding logic can read them directly.
// Ports       : clk, reset                 - clock, sync active-high reset
//               ex_*                       - instruction from EX, ex_ready
//               mem_req/we/addr/wdata      - memory request (registered)
//               mem_ack/mem_rdata          - memory response
//               wb_valid/reg_write/dest/data - write-back record
//               mem_error                  - timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int REG_BITS  = 2,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [3:0]           ex_opcode,
    input  logic [WORD_SIZE-1:0] ex_alu_result,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [REG_BITS-1:0]  ex_dest,
    input  logic                 ex_reg_write,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_BITS-1:0]  wb_dest,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 mem_error
);

    mem_state_t          state;
    logic [REG_BITS-1:0] pend_dest;
    logic                wait_expire;

    assign ex_ready = (state == MEM_IDLE);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == MEM_IDLE),
        .enable (state == MEM_ACCESS),
        .expire (wait_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MEM_IDLE;
            pend_dest    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            mem_error    <= 1'b0;
        end else begin
            // Pulses default low; wb_* payload holds for forwarding.
            wb_valid  <= 1'b0;
            mem_error <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (ex_valid) begin
                        if (is_mem_op(ex_opcode)) begin
                            mem_addr  <= ex_alu_result;
                            mem_wdata <= ex_store_data;
                            mem_we    <= (ex_opcode == SWD_OP);
                            mem_req   <= 1'b1;
                            pend_dest <= ex_dest;
                            state     <= MEM_ACCESS;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_result;
                            wb_dest      <= ex_dest;
                            wb_reg_write <= ex_reg_write;
                        end
                    end
                end
                MEM_ACCESS: begin
                    // Ack takes priority over an expiring wait in the same cycle.
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_dest      <= pend_dest;
                        wb_reg_write <= !mem_we;
                        wb_data      <= mem_we ? mem_addr : mem_rdata;
                        state        <= MEM_IDLE;
                    end else if (wait_expire) begin
                        mem_req      <= 1'b0;
                        mem_error    <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_dest      <= pend_dest;
                        wb_reg_write <= 1'b0;
                        wb_data      <= mem_addr;
                        state        <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int W  = 16;
    localparam int RB = 2;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_opcode;
    logic [W-1:0]  ex_alu_result;
    logic [W-1:0]  ex_store_data;
    logic [RB-1:0] ex_dest;
    logic          ex_reg_write;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          wb_valid;
    logic          wb_reg_write;
    logic [RB-1:0] wb_dest;
    logic [W-1:0]  wb_data;
    logic          mem_error;

    int n_vec  = 0;
    int n_fail = 0;

    mem_access_stage #(
        .WORD_SIZE (W),
        .REG_BITS  (RB),
        .MAX_WAIT  (MW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .mem_error     (mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        logic [W-1:0]  alu;
        logic [RB-1:0] dest;
        logic          rw;
        logic [W-1:0]  exp_data;
        logic [RB-1:0] exp_dest;
        logic          exp_rw;
    } alu_vec_t;

    alu_vec_t vecs [5];

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] alu,
                         input logic [W-1:0] sd, input logic [RB-1:0] dest,
                         input logic rw);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_dest       = dest;
        ex_reg_write  = rw;
    endtask

    initial begin
        vecs[0] = '{ADI_OP, 16'h0012, 2'd1, 1'b1, 16'h0012, 2'd1, 1'b1};
        vecs[1] = '{ORI_OP, 16'hFFFF, 2'd3, 1'b1, 16'hFFFF, 2'd3, 1'b1};
        vecs[2] = '{ADI_OP, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0};
        vecs[3] = '{4'd0,   16'hA5A5, 2'd2, 1'b1, 16'hA5A5, 2'd2, 1'b1};
        vecs[4] = '{ORI_OP, 16'h8001, 2'd1, 1'b0, 16'h8001, 2'd1, 1'b0};

        reset = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_alu_result = '0;
        ex_store_data = '0; ex_dest = '0; ex_reg_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst ex_ready", 32'(ex_ready), 32'd1);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", 32'(wb_data), 32'd0);
        chk("rst mem_error", 32'(mem_error), 32'd0);
        reset = 1'b0;

        // ALU pass-through, back-to-back every cycle
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].op, vecs[i].alu, 16'h5555, vecs[i].dest, vecs[i].rw);
            step();
            chk("alu wb_valid", 32'(wb_valid), 32'd1);
            chk("alu wb_data", 32'(wb_data), 32'(vecs[i].exp_data));
            chk("alu wb_dest", 32'(wb_dest), 32'(vecs[i].exp_dest));
            chk("alu wb_reg_write", 32'(wb_reg_write), 32'(vecs[i].exp_rw));
            chk("alu ex_ready", 32'(ex_ready), 32'd1);
        end
        ex_valid = 1'b0;
        step();
        chk("idle wb_valid", 32'(wb_valid), 32'd0);
        chk("hold wb_data", 32'(wb_data), 32'h8001);

        // LWD, ack after three waiting cycles
        drive(LWD_OP, 16'h0040, 16'h5555, 2'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lwd mem_req", 32'(mem_req), 32'd1);
            chk("lwd mem_we", 32'(mem_we), 32'd0);
            chk("lwd mem_addr", 32'(mem_addr), 32'h0040);
            chk("lwd ex_ready", 32'(ex_ready), 32'd0);
            chk("lwd wb_valid", 32'(wb_valid), 32'd0);
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        chk("lwd done wb_valid", 32'(wb_valid), 32'd1);
        chk("lwd done mem_req", 32'(mem_req), 32'd0);
        chk("lwd wb_data", 32'(wb_data), 32'hBEEF);
        chk("lwd wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("lwd wb_dest", 32'(wb_dest), 32'd2);
        chk("lwd done ex_ready", 32'(ex_ready), 32'd1);

        // SWD with immediate ack: 2-cycle latency
        drive(SWD_OP, 16'h0041, 16'h1234, 2'd3, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("swd mem_req", 32'(mem_req), 32'd1);
        chk("swd mem_we", 32'(mem_we), 32'd1);
        chk("swd mem_addr", 32'(mem_addr), 32'h0041);
        chk("swd mem_wdata", 32'(mem_wdata), 32'h1234);
        chk("swd early wb_valid", 32'(wb_valid), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("swd wb_valid", 32'(wb_valid), 32'd1);
        chk("swd wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("swd wb_data", 32'(wb_data), 32'h0041);
        chk("swd done mem_req", 32'(mem_req), 32'd0);
        step();
        chk("swd pulse end", 32'(wb_valid), 32'd0);

        // LWD timeout after MW request cycles, then a stray ack
        drive(LWD_OP, 16'h0077, 16'h0000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        for (int i = 1; i < MW; i++) begin
            step();
            chk("to wait mem_req", 32'(mem_req), 32'd1);
            chk("to wait mem_error", 32'(mem_error), 32'd0);
        end
        step();
        chk("to mem_req", 32'(mem_req), 32'd0);
        chk("to mem_error", 32'(mem_error), 32'd1);
        chk("to wb_valid", 32'(wb_valid), 32'd1);
        chk("to wb_reg_write", 32'(wb_reg_write), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stray mem_error", 32'(mem_error), 32'd0);
        chk("stray wb_valid", 32'(wb_valid), 32'd0);
        chk("stray mem_req", 32'(mem_req), 32'd0);
        chk("stray ex_ready", 32'(ex_ready), 32'd1);
        chk("stray wb_reg_write", 32'(wb_reg_write), 32'd0);

        // Ack on the last permitted cycle beats the timeout
        drive(LWD_OP, 16'h0099, 16'h0000, 2'd3, 1'b1);
        step();
        ex_valid = 1'b0;
        for (int i = 1; i < MW; i++) step();
        chk("late mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 16'h7E57;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("late mem_error", 32'(mem_error), 32'd0);
        chk("late wb_valid", 32'(wb_valid), 32'd1);
        chk("late wb_data", 32'(wb_data), 32'h7E57);
        chk("late wb_reg_write", 32'(wb_reg_write), 32'd1);

        // Reset during ACCESS
        drive(LWD_OP, 16'h0010, 16'h0000, 2'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("mid mem_req", 32'(mem_req), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("mid rst mem_req", 32'(mem_req), 32'd0);
        chk("mid rst ex_ready", 32'(ex_ready), 32'd1);
        chk("mid rst wb_data", 32'(wb_data), 32'd0);
        chk("mid rst wb_dest", 32'(wb_dest), 32'd0);
        chk("mid rst wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("mid rst wb_valid", 32'(wb_valid), 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back ADI, ORI, LWD, ADI
        drive(ADI_OP, 16'h0101, 16'h0000, 2'd1, 1'b1);
        step();
        chk("b2b adi wb_data", 32'(wb_data), 32'h0101);
        chk("b2b adi wb_valid", 32'(wb_valid), 32'd1);
        drive(ORI_OP, 16'h0202, 16'h0000, 2'd2, 1'b1);
        step();
        chk("b2b ori wb_data", 32'(wb_data), 32'h0202);
        chk("b2b ori wb_valid", 32'(wb_valid), 32'd1);
        drive(LWD_OP, 16'h0300, 16'h0000, 2'd3, 1'b1);
        step();
        chk("b2b lwd wb_valid", 32'(wb_valid), 32'd0);
        chk("b2b lwd mem_req", 32'(mem_req), 32'd1);
        drive(ADI_OP, 16'h0404, 16'h0000, 2'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("b2b stall ex_ready", 32'(ex_ready), 32'd0);
            step();
            chk("b2b stall wb_valid", 32'(wb_valid), 32'd0);
        end
        mem_ack = 1'b1; mem_rdata = 16'h0CAF;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("b2b lwd done wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b lwd wb_data", 32'(wb_data), 32'h0CAF);
        chk("b2b lwd wb_dest", 32'(wb_dest), 32'd3);
        chk("b2b ready again", 32'(ex_ready), 32'd1);
        step();
        ex_valid = 1'b0;
        chk("b2b adi2 wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b adi2 wb_data", 32'(wb_data), 32'h0404);
        chk("b2b adi2 wb_dest", 32'(wb_dest), 32'd0);
        step();
        chk("b2b final wb_valid", 32'(wb_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
